// File: rtl/axis_pkt_stats.sv
// Per-packet statistics tracker fed by an AXI-Stream monitor stage, with a coherent snapshot handshake.
// Optional stall counter: define AXIS_PKT_STATS_STALL_EN to build it; otherwise stall_count is tied to 0.
module axis_pkt_stats #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tvalid,
    input  logic             xfer,
    input  logic             sop,
    input  logic             eop,
    input  logic             clear,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [LEN_W-1:0] last_len,
    output logic [LEN_W-1:0] min_len,
    output logic [LEN_W-1:0] max_len,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             in_pkt,
    output logic             oversize
);

    typedef enum logic {S_IDLE, S_PKT} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
    logic             comp;
    logic [LEN_W-1:0] comp_len;
    logic             ovf_hit;

    logic [LEN_W-1:0] live_last, live_min, live_max;
    logic [CNT_W-1:0] live_pkts, live_stall;

    assign beat_inc = (beat_cnt == LEN_MAX) ? beat_cnt : beat_cnt + LEN_W'(1);

    // NOTE: every output of this block gets a default before the case, so no path can leave a latch.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        comp         = 1'b0;
        comp_len     = beat_inc;
        ovf_hit      = 1'b0;
        case (state)
            S_IDLE: begin
                // Beats without sop here belong to a packet that began before we were tracking.
                if (xfer && sop) begin
                    if (eop) begin
                        comp     = 1'b1;
                        comp_len = LEN_W'(1);
                    end else begin
                        state_nxt    = S_PKT;
                        beat_cnt_nxt = LEN_W'(1);
                    end
                end
            end
            S_PKT: begin
                if (xfer) begin
                    ovf_hit = (beat_cnt == LEN_MAX);
                    if (eop) begin
                        comp      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        beat_cnt_nxt = beat_inc;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign in_pkt = (state == S_PKT);

    // Live statistics; clear wins over a completion landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            live_last <= '0;
            live_min  <= LEN_MAX;
            live_max  <= '0;
            live_pkts <= '0;
            oversize  <= 1'b0;
        end else begin
            if (comp) begin
                live_last <= comp_len;
                if (comp_len < live_min) live_min <= comp_len;
                if (comp_len > live_max) live_max <= comp_len;
                if (live_pkts != CNT_MAX) live_pkts <= live_pkts + CNT_W'(1);
            end
            if (ovf_hit) oversize <= 1'b1;
        end
    end

`ifdef AXIS_PKT_STATS_STALL_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            live_stall <= '0;
        end else if (state == S_PKT && i_tvalid && !xfer && live_stall != CNT_MAX) begin
            live_stall <= live_stall + CNT_W'(1);
        end
    end
`else
    logic stall_unused;
    assign stall_unused = i_tvalid;
    assign live_stall   = '0;
`endif

    // Snapshot copies the live values as they stood before this cycle's updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid  <= 1'b0;
            last_len    <= '0;
            min_len     <= LEN_MAX;
            max_len     <= '0;
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            snap_valid <= snap_req;
            if (snap_req) begin
                last_len    <= live_last;
                min_len     <= live_min;
                max_len     <= live_max;
                pkt_count   <= live_pkts;
                stall_count <= live_stall;
            end
        end
    end

endmodule

// File: doc/axis_pkt_stats.md
Name: axis_pkt_stats

Overview:
Consumes the per-beat strobes of an AXI-Stream monitor stage (xfer/sop/eop plus raw tvalid) and accumulates per-packet statistics: last, min and max packet length, packet count, and in-packet stall cycles. A software-visible snapshot handshake latches a coherent copy of all statistics. Sits directly downstream of the stream monitor in debug and telemetry paths; it is purely observational and never touches the monitored bus.

Parameters:
LEN_W, 16, width of packet-length fields in beats; length saturates at 2^LEN_W-1.
CNT_W, 32, width of packet and stall counters; counters saturate at all-ones.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_tvalid  in  1  raw tvalid of the monitored bus, used for stall detection
xfer  in  1  beat transferred this cycle
sop  in  1  first beat of a packet; only meaningful when xfer=1
eop  in  1  last beat of a packet; only meaningful when xfer=1
clear  in  1  pulse: zero the accumulated live statistics
snap_req  in  1  pulse: request a snapshot
snap_valid  out  1  one-cycle pulse: snapshot outputs updated
last_len  out  LEN_W  length of most recent completed packet (snapshot)
min_len  out  LEN_W  minimum completed length (snapshot); all-ones if none
max_len  out  LEN_W  maximum completed length (snapshot); 0 if none
pkt_count  out  CNT_W  completed packets (snapshot)
stall_count  out  CNT_W  in-packet stall cycles (snapshot; see Optional Feature)
in_pkt  out  1  live: FSM is in S_PKT
oversize  out  1  sticky live flag: a packet length saturated

Behaviour:
- Reset values: FSM S_IDLE; beat counter 0; live and snapshot last_len=0, min_len=all-ones, max_len=0, pkt_count=0, stall_count=0; snap_valid=0; oversize=0.
- FSM, advances only on xfer=1:
  - S_IDLE: sop&&!eop -> S_PKT with beat counter=1. sop&&eop -> single-beat packet; complete with length 1 and stay in S_IDLE.
  - S_PKT: xfer&&!eop -> counter+1, saturating at 2^LEN_W-1. At saturation oversize sets and stays set until rst or clear. xfer&&eop -> complete with length counter+1 (saturating), go to S_IDLE.
  - xfer without sop in S_IDLE (tracker started mid-packet after reset): ignore the beat; stay in S_IDLE until the next sop.
- Completion, in the cycle after the eop beat:
  - live last_len = L.
  - live min_len = min(min_len, L); live max_len = max(max_len, L).
  - live pkt_count += 1, saturating.
- Stall: in S_PKT, a cycle with i_tvalid && !xfer increments live stall_count, saturating. Valid-low cycles inside a packet are not stalls.
- clear:
  - Next cycle, live stats return to reset values and oversize=0.
  - FSM state and beat counter are untouched, so an in-flight packet still completes and is counted after the clear.
  - A completion in the same cycle as clear is discarded.
- Snapshot:
  - snap_req=1 at cycle N -> all snapshot outputs load the live values as they stand at the end of cycle N (before any update from cycle N), and snap_valid=1 at N+1.
  - Back-to-back requests each produce a pulse.
  - snap_req and clear in the same cycle: the snapshot captures pre-clear values, then the live stats clear.
- in_pkt and oversize are registered live outputs, not snapshot values.
- rst mid-packet: everything returns to reset values; the partial packet is dropped.

Optional Feature:
AXIS_PKT_STATS_STALL_EN
- Defined: the stall counter is built as described.
- Undefined: the stall counter logic is omitted and stall_count is tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset, then snap_req -> snap_valid pulses next cycle with pkt_count=0, min_len=0xFFFF, max_len=0, last_len=0.
- Packets of lengths 4, 1, 9 with tready always high, then snap_req -> pkt_count=3, last_len=9, min_len=1, max_len=9, stall_count=0.
- 5-beat packet with tready low for 3 cycles mid-packet (tvalid high), plus 2 valid-low cycles -> stall_count=3 when the macro is defined, 0 when it is undefined.
- clear asserted on beat 2 of a 6-beat packet, with snap_req in the same cycle -> that snapshot shows pre-clear stats. A later snapshot shows pkt_count=1, last_len=6, min_len=max_len=6.
- LEN_W=4, 20-beat packet -> last_len=15, oversize=1. clear -> oversize=0.
- rst during beat 3 of a packet, then a stream resuming mid-packet without sop followed by a 2-beat packet -> pkt_count=1, last_len=2, in_pkt=0 at end.
